// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Optional misaligned-fetch checking is enabled by defining IMEM_MISALIGN_CHECK_EN.
package imem_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_e;

  function automatic logic misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word store: one write port, one registered read port.
// Only the read-data register is reset; the storage keeps its contents across reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [IDX_W-1:0]   raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read samples the pre-edge contents, so a same-edge write is not seen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_fetch_resp.sv
// Fixed-latency instruction fetch responder over a preloadable word store.
// Define IMEM_MISALIGN_CHECK_EN to flag misaligned fetches (fault + NOP).
module imem_fetch_resp
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [INSTR_W-1:0] resp_instr,
  output logic               resp_fault,
  input  logic               resp_ready,
  input  logic               ld_en,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [INSTR_W-1:0] ld_data
);

  localparam int unsigned IDX_W    = ADDR_W - 2;
  localparam logic [2:0]  CNT_LOAD = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

  fetch_state_e       state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               mis_q, mis_d;
  logic               fault_q, fault_d;
  logic               rdy_q;
  logic               accept;
  logic               req_mis;
  logic               rd_en;
  logic [IDX_W-1:0]   rd_idx;
  logic [INSTR_W-1:0] rdata;
  logic               unused_ld_lo;

`ifdef IMEM_MISALIGN_CHECK_EN
  assign req_mis = misaligned(req_addr[1:0]);
`else
  assign req_mis = 1'b0;
`endif

  assign accept = req_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    fault_d = fault_q;
    rd_en   = 1'b0;
    rd_idx  = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d = req_addr[ADDR_W-1:2];
          mis_d = req_mis;
          if (LATENCY == 1) begin
            state_d = RESP;
            rd_en   = 1'b1;
            rd_idx  = req_addr[ADDR_W-1:2];
            fault_d = req_mis;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rd_en   = 1'b1;
          fault_d = mis_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // req_ready is a registered decode so it stays low through reset and has no input path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      fault_q <= fault_d;
      rdy_q   <= (state_d == IDLE);
    end
  end

  imem_array #(
    .IDX_W (IDX_W)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .we_i    (ld_en),
    .waddr_i (ld_addr[ADDR_W-1:2]),
    .wdata_i (ld_data),
    .re_i    (rd_en),
    .raddr_i (rd_idx),
    .rdata_o (rdata)
  );

  assign req_ready    = rdy_q;
  assign resp_valid   = (state_q == RESP);
  assign unused_ld_lo = ^ld_addr[1:0];

`ifdef IMEM_MISALIGN_CHECK_EN
  assign resp_fault = fault_q;
  assign resp_instr = fault_q ? RV_NOP : rdata;
`else
  logic unused_mis;
  assign unused_mis = ^{req_addr[1:0], mis_q, fault_q};
  assign resp_fault = 1'b0;
  assign resp_instr = rdata;
`endif

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Self-checking bench: three responders (LATENCY 1, 2, 5) against an array-based reference.
module tb_imem_fetch_resp;
  import imem_pkg::*;

  localparam int NK = 3;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NK-1:0]         req_valid;
  logic [NK-1:0][7:0]    req_addr;
  logic [NK-1:0]         req_ready;
  logic [NK-1:0]         resp_valid;
  logic [NK-1:0][31:0]   resp_instr;
  logic [NK-1:0]         resp_fault;
  logic [NK-1:0]         resp_ready;
  logic                  ld_en;
  logic [7:0]            ld_addr;
  logic [31:0]           ld_data;

  int checks   = 0;
  int failures = 0;
  logic [31:0] mem_m [64];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NK; g++) begin : g_dut
    imem_fetch_resp #(
      .ADDR_W  (8),
      .LATENCY ((g == 0) ? 1 : ((g == 1) ? 2 : 5))
    ) u_dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_addr   (req_addr[g]),
      .req_ready  (req_ready[g]),
      .resp_valid (resp_valid[g]),
      .resp_instr (resp_instr[g]),
      .resp_fault (resp_fault[g]),
      .resp_ready (resp_ready[g]),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data)
    );
  end

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 5;
    endcase
  endfunction

  function automatic logic [31:0] exp_instr(input logic [7:0] a);
`ifdef IMEM_MISALIGN_CHECK_EN
    if (a[1:0] != 2'b00) return 32'h0000_0013;
`endif
    return mem_m[a[7:2]];
  endfunction

  function automatic logic exp_fault(input logic [7:0] a);
`ifdef IMEM_MISALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clock);
    ld_en = 1'b0;
    mem_m[a[7:2]] = d;
  endtask

  task automatic wait_ready(input int k);
    int t = 0;
    while (req_ready[k] !== 1'b1 && t < 50) begin
      @(negedge clock);
      t++;
    end
    chk($sformatf("ready_wait k%0d", k), {31'b0, req_ready[k]}, 32'd1);
  endtask

  // One transaction: request, latency check, hold for `hold` cycles, handshake.
  task automatic fetch(input int k, input logic [7:0] a, input int hold,
                       input bit ld_entry, input logic [31:0] ld_val,
                       output logic [31:0] got);
    int lat = lat_of(k);
    logic [31:0] ei;
    logic        ef;
    logic [7:0]  la;
    ei = exp_instr(a);
    ef = exp_fault(a);
    la = {a[7:2], 2'($urandom_range(0, 3))};
    wait_ready(k);
    req_valid[k] = 1'b1; req_addr[k] = a; resp_ready[k] = 1'b0;
    if (ld_entry && lat == 1) begin
      ld_en = 1'b1; ld_addr = la; ld_data = ld_val;
    end
    for (int n = 1; n <= lat; n++) begin
      @(negedge clock);
      if (n == 1) begin
        chk($sformatf("busy k%0d", k), {31'b0, req_ready[k]}, 32'd0);
        req_addr[k] = a ^ 8'h40;
      end
      if (ld_entry && n == lat) begin
        ld_en = 1'b0;
        mem_m[a[7:2]] = ld_val;
      end
      if (ld_entry && lat > 1 && n == lat - 1) begin
        ld_en = 1'b1; ld_addr = la; ld_data = ld_val;
      end
      chk($sformatf("lat k%0d n%0d", k, n), {31'b0, resp_valid[k]}, 32'(n >= lat));
    end
    chk($sformatf("instr k%0d a%h", k, a), resp_instr[k], ei);
    chk($sformatf("fault k%0d a%h", k, a), {31'b0, resp_fault[k]}, {31'b0, ef});
    got = resp_instr[k];
    for (int h = 1; h <= hold; h++) begin
      @(negedge clock);
      chk($sformatf("hold_valid k%0d h%0d", k, h), {31'b0, resp_valid[k]}, 32'd1);
      chk($sformatf("hold_instr k%0d h%0d", k, h), resp_instr[k], ei);
      chk($sformatf("hold_fault k%0d h%0d", k, h), {31'b0, resp_fault[k]}, {31'b0, ef});
      chk($sformatf("hold_rdy k%0d h%0d", k, h), {31'b0, req_ready[k]}, 32'd0);
    end
    req_valid[k] = 1'b0; resp_ready[k] = 1'b1;
    @(negedge clock);
    chk($sformatf("done_valid k%0d", k), {31'b0, resp_valid[k]}, 32'd0);
    chk($sformatf("done_rdy k%0d", k), {31'b0, req_ready[k]}, 32'd1);
    resp_ready[k] = 1'b0;
  endtask

  initial begin
    logic [31:0] got, old_w, new_w;
    logic [7:0]  a;
    reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    req_valid = '0; req_addr = '0; resp_ready = '0;
    repeat (2) @(negedge clock);
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("rst_rdy k%0d", k), {31'b0, req_ready[k]}, 32'd0);
      chk($sformatf("rst_valid k%0d", k), {31'b0, resp_valid[k]}, 32'd0);
      chk($sformatf("rst_instr k%0d", k), resp_instr[k], 32'd0);
      chk($sformatf("rst_fault k%0d", k), {31'b0, resp_fault[k]}, 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    for (int k = 0; k < NK; k++)
      chk($sformatf("post_rst_rdy k%0d", k), {31'b0, req_ready[k]}, 32'd1);

    for (int w = 0; w < 64; w++) begin
      a = 8'(w << 2) | 8'($urandom_range(0, 3));
      load_word(a, (w == 1) ? 32'h0050_0093 : $urandom());
    end

    // Basic fetch, then a held response with ignored requests.
    fetch(1, 8'h04, 0, 1'b0, 32'h0, got);
    chk("word1", got, 32'h0050_0093);
    fetch(1, 8'h04, 3, 1'b0, 32'h0, got);

    // LATENCY=1 back-to-back: one response every two cycles at most.
    wait_ready(0);
    req_valid[0] = 1'b1; req_addr[0] = 8'h00; resp_ready[0] = 1'b1;
    @(negedge clock);
    chk("b2b_v0", {31'b0, resp_valid[0]}, 32'd1);
    chk("b2b_i0", resp_instr[0], mem_m[0]);
    chk("b2b_r0", {31'b0, req_ready[0]}, 32'd0);
    req_addr[0] = 8'h04;
    @(negedge clock);
    chk("b2b_gap_v", {31'b0, resp_valid[0]}, 32'd0);
    chk("b2b_gap_r", {31'b0, req_ready[0]}, 32'd1);
    @(negedge clock);
    req_valid[0] = 1'b0;
    chk("b2b_v1", {31'b0, resp_valid[0]}, 32'd1);
    chk("b2b_i1", resp_instr[0], 32'h0050_0093);
    @(negedge clock);
    chk("b2b_end_v", {31'b0, resp_valid[0]}, 32'd0);
    resp_ready[0] = 1'b0;

    // Misaligned fetch.
    fetch(1, 8'h06, 0, 1'b0, 32'h0, got);
`ifdef IMEM_MISALIGN_CHECK_EN
    chk("misalign_nop", got, 32'h0000_0013);
`else
    chk("misalign_off", got, 32'h0050_0093);
`endif

    // Reset during WAIT abandons the fetch.
    wait_ready(2);
    req_valid[2] = 1'b1; req_addr[2] = 8'h08;
    @(negedge clock);
    req_valid[2] = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_valid", {31'b0, resp_valid[2]}, 32'd0);
    chk("midrst_rdy", {31'b0, req_ready[2]}, 32'd0);
    chk("midrst_instr", resp_instr[2], 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_rdy_after", {31'b0, req_ready[2]}, 32'd1);
    for (int n = 0; n < 6; n++) begin
      chk($sformatf("midrst_no_resp n%0d", n), {31'b0, resp_valid[2]}, 32'd0);
      @(negedge clock);
    end
    fetch(2, 8'h04, 1, 1'b0, 32'h0, got);
    chk("midrst_mem_kept", got, 32'h0050_0093);

    // Write on the RESP-entry edge is not visible; refetch sees it.
    old_w = mem_m[3];
    new_w = ~old_w ^ 32'h1234_5678;
    fetch(1, 8'h0C, 0, 1'b1, new_w, got);
    chk("ld_old", got, old_w);
    fetch(1, 8'h0C, 0, 1'b0, 32'h0, got);
    chk("ld_new", got, new_w);

    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, NK - 1);
      if ($urandom_range(0, 3) == 0) load_word(8'($urandom_range(0, 255)), $urandom());
      fetch(k, 8'($urandom_range(0, 255)), $urandom_range(0, 3),
            ($urandom_range(0, 4) == 0), $urandom(), got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
